// File: rtl/serial_add_ctrl_pkg.sv
// Shared state encoding and sizing helper for the bit-serial adder controller.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the whole datapath of the bit-serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full_adder evaluation per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] s_nxt;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fa_s, fa_co;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    full_adder u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB; truncation also covers WIDTH == 1.
    assign s_nxt = WIDTH'({fa_s, s_sh_q} >> 1);

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                s_sh_d  = s_nxt;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    sum_d   = s_nxt;
                    cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB on this last bit cycle.
                    ovf_d   = carry_q ^ fa_co;
`endif
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): vector table, scoreboard, corner sequences.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, cin;
    logic [W-1:0] a, b, sum;
    logic         busy, done, cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t sb_q[$];
    vec_t prev;
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   cyc      = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] t;
        vec_t v;
        t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        v.a    = x;
        v.b    = y;
        v.cin  = c;
        v.sum  = t[W-1:0];
        v.cout = t[W];
        v.ovf  = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return v;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest pending add.
    always @(negedge clk) begin
        if (!rst && done) begin
            vec_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("sum", sum, e.sum);
                check("cout", cout, e.cout);
`ifdef SERIAL_ADD_OVF_EN
                check("ovf", ovf, e.ovf);
`endif
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 40);
    endtask

    task automatic launch(input vec_t v);
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; start = 1'b1;
        sb_q.push_back(v);
        @(posedge clk); #1;
        start = 1'b0;
        a = ~v.a; b = v.b + 8'h5; cin = ~v.cin;
        check("busy_run", busy, 1);
    endtask

    task automatic do_add(input vec_t v);
        int n;
        launch(v);
        n = 0;
        while (n < 40) begin
            if (n == 3) begin
                check("sum_hold", sum, prev.sum);
                check("cout_hold", cout, prev.cout);
            end
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
        check("latency", n, W);
        check("busy_at_done", busy, 0);
        prev = v;
        @(posedge clk);
    endtask

    vec_t tbl[8];

    initial begin
        int n, d0, last;
        vec_t v1, v2, bb[4];

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0};
        tbl[7] = '{8'hC0, 8'h30, 1'b0, 8'hF0, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        prev = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 8; i++) do_add(tbl[i]);

        // start during RUN must be ignored and not queued
        v1 = mk(8'h21, 8'h43, 1'b0);
        v2 = mk(8'hEE, 8'hEE, 1'b1);
        d0 = done_cnt;
        launch(v1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        a = v2.a; b = v2.b; cin = v2.cin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(n);
        check("ign_done_seen", done, 1);
        check("ign_latency", n, W - 3);
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("ign_one_done", done_cnt - d0, 1);
        prev = v1;

        // reset mid-RUN aborts without a done pulse
        d0 = done_cnt;
        launch(mk(8'h9C, 8'h4D, 1'b1));
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        prev = '0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        do_add(tbl[0]);

        // back-to-back with start held high
        bb[0] = mk(8'h11, 8'h22, 1'b0);
        bb[1] = mk(8'hF0, 8'h0F, 1'b1);
        bb[2] = mk(8'h81, 8'hC3, 1'b0);
        bb[3] = mk(8'h3B, 8'h6E, 1'b1);
        @(negedge clk);
        a = bb[0].a; b = bb[0].b; cin = bb[0].cin; start = 1'b1;
        sb_q.push_back(bb[0]);
        last = 0;
        for (int k = 0; k < 4; k++) begin
            wait_done(n);
            check("b2b_done_seen", done, 1);
            if (k > 0) check("b2b_interval", cyc - last, W + 2);
            last = cyc;
            if (k < 3) begin
                a = bb[k+1].a; b = bb[k+1].b; cin = bb[k+1].cin;
                sb_q.push_back(bb[k+1]);
            end else begin
                start = 1'b0;
            end
        end
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("sb_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
